scan_ctrl_multi: RTL
====================

Name: scan_ctrl_multi

Overview:
- Parametrised scan-test sequencer. Repeatedly shifts a scan chain of configurable length, applies configurable capture pulses, and waits a configurable gap between passes.
- Generates a glitch-free gated scan_clk and a test_se that is stable around every scan_clk pulse.
- Adds start/busy/done/abort handshaking, count-limited and continuous modes, graceful stop, and an abort on ADPLL lock loss.
- Sits between the ADPLL-clocked top level and the scan-chain DUT; the sub-block reset pulse it emits clears the chain logic after each run.

Parameters:
- CHAIN_LEN, 11, scan_clk pulses per shift phase (>=1).
- CNT_W, 12, width of the shift/capture/gap counter; must hold max(CHAIN_LEN, CAPTURE_CYC, GAP_CYC).
- CAPTURE_CYC, 1, scan_clk pulses with test_se=0 per pass (>=1).
- GAP_CYC, 6, clk cycles with no scan_clk after capture (>=1).
- SCAN_W, 20, width of scan_num and pass_cnt.
- RST_CYC, 3, clk cycles sub_rst is held low after a run ends (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ADPLL_LOCK  in  1  PLL lock; 0 aborts any active run.
- start  in  1  one-cycle request; accepted only in IDLE.
- stop  in  1  level; finish the current pass, then DONE.
- cont_mode  in  1  sampled at start; 1 = run until stop.
- scan_num  in  SCAN_W  number of passes, sampled at start.
- busy  out  1  high from start acceptance until return to IDLE.
- scan_clk  out  1  gated clock = clk AND clk_en.
- shift_en  out  1  clk_en (negedge register), exported.
- test_se  out  1  scan enable (negedge register).
- scan_done  out  1  one-cycle pulse on normal completion.
- scan_abort  out  1  one-cycle pulse on lock-loss abort.
- sub_rst  out  1  active-low reset to the scan logic.
- pass_cnt  out  SCAN_W  completed passes in the current run.

Behaviour:
- Reset values: state=IDLE, counters 0, busy=0, clk_en=0, test_se=1, scan_done=0, scan_abort=0, sub_rst=0. sub_rst is released to 1 on the first negedge after rst_n deasserts.
- States:
  - IDLE -> SHIFT at the posedge where start=1 AND ADPLL_LOCK=1 AND (cont_mode=1 OR scan_num!=0). Otherwise start is ignored with no response.
  - On acceptance: latch scan_num and cont_mode, clear pass_cnt, set busy=1.
  - SHIFT: CHAIN_LEN cycles, then CAPTURE.
  - CAPTURE: CAPTURE_CYC cycles, then GAP.
  - GAP: GAP_CYC cycles. At the end, pass_cnt increments by 1. Then:
    - go to DONE if (cont_mode=0 AND pass_cnt+1==latched scan_num) OR stop=1;
    - otherwise return to SHIFT.
  - DONE: one cycle with scan_done=1, then SUBRST.
  - SUBRST: RST_CYC cycles, then IDLE; busy drops on entering IDLE.
- Per-state counter: cleared on every state entry and counts clk cycles.
- clk_en and test_se are updated on negedge clk from the current state:
  - clk_en = (SHIFT or CAPTURE) AND ADPLL_LOCK.
  - test_se = 0 only in CAPTURE and GAP, else 1.
- Result: exactly CHAIN_LEN pulses with test_se=1, then CAPTURE_CYC pulses with test_se=0. scan_clk lags state entry by one cycle. test_se never changes while clk is high.
- scan_clk is additionally ANDed combinationally with ADPLL_LOCK, so lock loss kills pulses immediately.
- sub_rst is registered on negedge; it is 0 while in SUBRST, else 1.
- Lock loss:
  - ADPLL_LOCK=0 in SHIFT/CAPTURE/GAP: next posedge goes to SUBRST with scan_abort=1 for one cycle.
  - No scan_done, and pass_cnt holds its value.
  - Lock loss in DONE/SUBRST has no effect.
- stop is sampled only at the end of GAP. stop in IDLE is ignored.
- start while busy is ignored.
- pass_cnt wraps modulo 2^SCAN_W in continuous mode; with cont_mode=0 it never exceeds the latched scan_num.
- rst_n asserted mid-run: immediate return to reset values, with no done or abort pulse.

Test Plan:
1. Defaults, scan_num=2, lock=1, one start pulse:
   - 2 passes of 11 pulses at test_se=1, then 1 pulse at test_se=0, then a 6-cycle gap;
   - scan_done pulses once, pass_cnt=2;
   - sub_rst is low 3 cycles, then busy=0.
2. scan_num=0 with cont_mode=0, start:
   - busy stays 0, no scan_clk, no sub_rst pulse.
3. cont_mode=1, stop raised during pass 4's SHIFT:
   - pass 4 completes, scan_done fires, pass_cnt=4.
4. ADPLL_LOCK dropped after the 5th shift pulse of pass 1:
   - no further scan_clk pulses, scan_abort pulses once, scan_done never;
   - sub_rst is low 3 cycles, pass_cnt=0, busy=0.
5. CHAIN_LEN=3, CAPTURE_CYC=2, GAP_CYC=1, scan_num=1:
   - exactly 3+2 scan_clk pulses;
   - test_se is stable across every scan_clk high phase (assertion).
6. rst_n pulsed mid-CAPTURE:
   - all outputs return to reset values asynchronously;
   - a new start after release runs normally.

Source files
------------

// File: rtl/scan_ctrl_multi.sv
// Scan-test sequencer: repeats SHIFT/CAPTURE/GAP passes on a gated scan_clk,
// with start/stop/abort handshaking and a post-run sub-block reset pulse.
module scan_ctrl_multi #(
  parameter int CHAIN_LEN   = 11,
  parameter int CNT_W       = 12,
  parameter int CAPTURE_CYC = 1,
  parameter int GAP_CYC     = 6,
  parameter int SCAN_W      = 20,
  parameter int RST_CYC     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ADPLL_LOCK,
  input  logic              start,
  input  logic              stop,
  input  logic              cont_mode,
  input  logic [SCAN_W-1:0] scan_num,
  output logic              busy,
  output logic              scan_clk,
  output logic              shift_en,
  output logic              test_se,
  output logic              scan_done,
  output logic              scan_abort,
  output logic              sub_rst,
  output logic [SCAN_W-1:0] pass_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    GAP,
    DONE,
    SUBRST
  } state_t;

  localparam logic [CNT_W-1:0] SHIFT_LAST   = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CAPTURE_LAST = CNT_W'(CAPTURE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYC - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [SCAN_W-1:0] num_lat;
  logic              cont_lat;
  logic              clk_en;
  logic [SCAN_W-1:0] pass_next;
  logic              active;

  assign pass_next = pass_cnt + 1'b1;
  assign active    = (state == SHIFT) || (state == CAPTURE) || (state == GAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      num_lat    <= '0;
      cont_lat   <= 1'b0;
      pass_cnt   <= '0;
      busy       <= 1'b0;
      scan_done  <= 1'b0;
      scan_abort <= 1'b0;
    end else begin
      scan_done  <= 1'b0;
      scan_abort <= 1'b0;
      // Lock loss overrides any pass-sequencing decision.
      if (active && !ADPLL_LOCK) begin
        state      <= SUBRST;
        cnt        <= '0;
        scan_abort <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start && ADPLL_LOCK && (cont_mode || (scan_num != '0))) begin
              state    <= SHIFT;
              cnt      <= '0;
              num_lat  <= scan_num;
              cont_lat <= cont_mode;
              pass_cnt <= '0;
              busy     <= 1'b1;
            end
          end
          SHIFT: begin
            if (cnt == SHIFT_LAST) begin
              state <= CAPTURE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          CAPTURE: begin
            if (cnt == CAPTURE_LAST) begin
              state <= GAP;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          GAP: begin
            if (cnt == GAP_LAST) begin
              cnt      <= '0;
              pass_cnt <= pass_next;
              if ((!cont_lat && (pass_next == num_lat)) || stop) begin
                state     <= DONE;
                scan_done <= 1'b1;
              end else begin
                state <= SHIFT;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DONE: begin
            state <= SUBRST;
            cnt   <= '0;
          end
          SUBRST: begin
            if (cnt == RST_LAST) begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Falling-edge updates keep clk_en and test_se stable for the whole high phase.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_en  <= 1'b0;
      test_se <= 1'b1;
      sub_rst <= 1'b0;
    end else begin
      clk_en  <= ((state == SHIFT) || (state == CAPTURE)) && ADPLL_LOCK;
      test_se <= !((state == CAPTURE) || (state == GAP));
      sub_rst <= (state != SUBRST);
    end
  end

  assign shift_en = clk_en;
  assign scan_clk = clk & clk_en & ADPLL_LOCK;

endmodule
